gate_truth_checker: RTL and testbench
=====================================

// Module: gate_truth_checker
// PURPOSE
//  Synthesizable stimulus/response checker for a 2-input combinational gate under test.
//  On a start pulse it drives the four input vectors {a,b}=00,01,10,11 onto the gate.
//  After each vector settles it samples the gate output and compares it to a truth-table parameter.
//  It reports per-vector mismatches, an error count and a pass flag; it is the on-chip self-test
//  counterpart to a gate such as nand_gate.
// PARAMETERS
//  TRUTH_TABLE    4'b0111  expected y, indexed by {a,b}; bit i = expected y for vector i (default = NAND)
//  SETTLE_CYCLES  2        extra cycles each vector is held before sampling (>=0)
//  STOP_ON_FAIL   0        1: end the sweep at the first mismatching vector
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  begin a sweep; sampled only in IDLE
//  gate_a     out  1  input a to the gate under test
//  gate_b     out  1  input b to the gate under test
//  gate_y     in   1  output of the gate under test
//  busy       out  1  high while a sweep is in progress (DRIVE state)
//  done       out  1  one-cycle pulse when the sweep ends
//  pass       out  1  1 = last sweep had zero mismatches; held until the next start
//  err_count  out  3  mismatches in the last sweep (0..4)
//  err_mask   out  4  bit i set if vector i mismatched in the last sweep
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; gate_a, gate_b, busy, done, pass all 0; err_count=0; err_mask=0; internal counters 0.
//   - Reset asserted mid-sweep aborts immediately and no done pulse is produced.
//  All outputs are registered.
//  FSM: IDLE -> DRIVE -> REPORT -> IDLE.
//   - IDLE:
//     - gate_a=gate_b=0; busy=0.
//     - start=1 at an edge -> DRIVE with vec=0, settle counter=0, err_count/err_mask cleared, pass=0.
//   - DRIVE:
//     - busy=1; {gate_a,gate_b}=vec.
//     - Each vector is held exactly SETTLE_CYCLES+1 cycles.
//     - At the edge ending the last cycle of the vector, compare gate_y with TRUTH_TABLE[vec].
//       On mismatch set err_mask[vec] and increment err_count.
//     - Then: if vec==3, or STOP_ON_FAIL=1 and a mismatch occurred -> REPORT; else vec+1 and counter=0.
//   - REPORT (one cycle):
//     - done=1; busy=0; gate_a=gate_b=0; pass=(err_count==0) using the final count.
//     - Next state IDLE.
//  Latency:
//   - Start sampled at edge E0 -> DRIVE occupies cycles 1..4*(SETTLE_CYCLES+1).
//   - done is high in cycle 4*(SETTLE_CYCLES+1)+1.
//  start while busy or in REPORT is ignored (no restart, no queueing).
//  start held high continuously produces back-to-back sweeps, each beginning from IDLE.
//  err_count, err_mask and pass hold their values from REPORT until the next accepted start.
//  Settle counter width = max(1,$clog2(SETTLE_CYCLES+1)); it never wraps past SETTLE_CYCLES.
//  gate_y is sampled directly, with no synchronizer (the gate is in the same clock domain).
// TESTING
//  1. Correct NAND, SETTLE_CYCLES=2: pulse start ->
//     a,b = 00,01,10,11 for 3 cycles each; done in cycle 13; pass=1, err_count=0, err_mask=0000.
//  2. Gate replaced by AND (y=a&b) -> err_mask=1111, err_count=4, pass=0; done still in cycle 13.
//  3. gate_y stuck at 1 -> err_mask=1000, err_count=1, pass=0.
//  4. STOP_ON_FAIL=1, gate_y stuck at 0 ->
//     done in cycle 4; err_mask=0001, err_count=1, pass=0; gate_a/gate_b return to 0.
//  5. start re-pulsed in cycle 6 -> ignored, single done at cycle 13.
//     rst_n low in cycle 5 of a new sweep -> all outputs 0 at once, no done;
//     start after release -> fresh sweep from vec 0.
//  6. SETTLE_CYCLES=0, correct NAND -> each vector held 1 cycle; done in cycle 5; pass=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// On-chip stimulus/response checker for a 2-input combinational gate.
// A start pulse sweeps {a,b} = 00, 01, 10, 11. Each vector is held for
// SETTLE_CYCLES+1 cycles. The gate output is sampled at the edge that ends
// the vector and is compared with TRUTH_TABLE. Per-vector mismatch flags,
// a mismatch count and a pass flag are reported.
// Every output comes straight from a flop.

module gate_truth_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b0111,  // bit i = expected y for {a,b} = i
  parameter int unsigned SETTLE_CYCLES = 2,        // extra hold cycles per vector
  parameter bit          STOP_ON_FAIL  = 1'b0      // end the sweep at the first mismatch
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  // Settle counter runs 0..SETTLE_CYCLES and is never allowed to wrap.
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next values of the registered outputs.
  logic [2:0]       err_count_d;
  logic [3:0]       err_mask_d;
  logic             pass_d;
  logic             gate_a_d, gate_b_d, busy_d, done_d;

  // Decoded conditions for the current DRIVE cycle.
  logic             last_cycle;
  logic             mismatch;

  assign last_cycle = (cnt_q == CNT_LAST);

  // State, vector index and settle counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sequencing, sampling of gate_y, result accumulation.
  // NOTE: every signal gets a default at the top of the block, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    err_count_d = err_count;
    err_mask_d  = err_mask;
    pass_d      = pass;
    mismatch    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRIVE;
          vec_d       = 2'd0;
          cnt_d       = '0;
          err_count_d = 3'd0;
          err_mask_d  = 4'd0;
          pass_d      = 1'b0;
        end
      end

      DRIVE: begin
        if (last_cycle) begin
          // The vector has settled for its full hold time; sample it now.
          mismatch = (gate_y != TRUTH_TABLE[vec_q]);
          if (mismatch) begin
            err_mask_d[vec_q] = 1'b1;
            err_count_d       = err_count + 3'd1;
          end
          if ((vec_q == 2'd3) || (STOP_ON_FAIL && mismatch)) begin
            state_d = REPORT;
            vec_d   = 2'd0;
            cnt_d   = '0;
            // Verdict uses the count including this final sample.
            pass_d  = (err_count_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REPORT: begin
        // Start is ignored here; a held start is taken again from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so the flops below present it
  // in the same cycle the FSM enters that state.
  always_comb begin
    busy_d   = (state_d == DRIVE);
    done_d   = (state_d == REPORT);
    gate_a_d = (state_d == DRIVE) && vec_d[1];
    gate_b_d = (state_d == DRIVE) && vec_d[0];
  end

  // Output registers; results hold from REPORT until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      err_mask  <= 4'd0;
    end else begin
      gate_a    <= gate_a_d;
      gate_b    <= gate_b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_count_d;
      err_mask  <= err_mask_d;
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. Three instances run side by side:
//   0: SETTLE_CYCLES=2, STOP_ON_FAIL=0
//   1: SETTLE_CYCLES=2, STOP_ON_FAIL=1
//   2: SETTLE_CYCLES=0, STOP_ON_FAIL=0
// Each instance drives a bench-side gate whose function is a 4-bit table.
// A sweep-level model predicts every output on every cycle. Literal checks
// pin the model to the hand-worked scenarios.

module tb_gate_truth_checker;

  localparam int         N        = 3;
  localparam int         S_TAB    [N] = '{2, 2, 0};
  localparam bit         STOP_TAB [N] = '{1'b0, 1'b1, 1'b0};
  localparam logic [3:0] TT       = 4'b0111;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [N-1:0][3:0]   gate_fn;
  logic [N-1:0]        gate_a, gate_b, gate_y, busy, done, pass;
  logic [N-1:0][2:0]   err_count;
  logic [N-1:0][3:0]   err_mask;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign gate_y[g] = gate_fn[g][{gate_a[g], gate_b[g]}];

    gate_truth_checker #(
      .TRUTH_TABLE  (TT),
      .SETTLE_CYCLES(S_TAB[g]),
      .STOP_ON_FAIL (STOP_TAB[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .gate_a   (gate_a[g]),
      .gate_b   (gate_b[g]),
      .gate_y   (gate_y[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .err_count(err_count[g]),
      .err_mask (err_mask[g])
    );
  end

  // ---------------- behavioural model ----------------
  // Number of vectors a sweep visits for a gate with table fn.
  function automatic int sweep_vecs(input logic [3:0] fn, input bit stop);
    logic [3:0] tt;
    tt = TT;
    for (int v = 0; v < 4; v++)
      if (stop && (fn[v] !== tt[v])) return v + 1;
    return 4;
  endfunction

  // Final mismatch mask of a sweep.
  function automatic logic [3:0] sweep_mask(input logic [3:0] fn, input bit stop);
    logic [3:0] tt;
    logic [3:0] m;
    tt = TT;
    m  = 4'd0;
    for (int v = 0; v < 4; v++) begin
      if (fn[v] !== tt[v]) begin
        m[v] = 1'b1;
        if (stop) return m;
      end
    end
    return m;
  endfunction

  // Model state per instance: k = cycle index within the sweep
  // (0 = not sweeping, 1..nd = drive cycles, nd+1 = report cycle).
  int         k        [N];
  logic [3:0] sw_fn    [N];
  bit         have_res [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        k[i]        <= 0;
        sw_fn[i]    <= 4'd0;
        have_res[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (k[i] == 0) begin
          if (start) begin
            k[i]        <= 1;
            sw_fn[i]    <= gate_fn[i];
            have_res[i] <= 1'b0;
          end
        end else if (k[i] <= sweep_vecs(sw_fn[i], STOP_TAB[i]) * (S_TAB[i] + 1)) begin
          k[i] <= k[i] + 1;
        end else begin
          k[i]        <= 0;
          have_res[i] <= 1'b1;
        end
      end
    end
  end

  // Packing: {gate_a, gate_b, busy, done, pass, err_count[2:0], err_mask[3:0]}
  function automatic logic [11:0] exp_out(input int i);
    int         s1, nd, v;
    logic [3:0] fm, pm;
    s1 = S_TAB[i] + 1;
    nd = sweep_vecs(sw_fn[i], STOP_TAB[i]) * s1;
    fm = sweep_mask(sw_fn[i], STOP_TAB[i]);
    if (k[i] == 0) begin
      if (!have_res[i]) return 12'd0;
      return {4'b0000, (fm == 4'd0), 3'($countones(fm)), fm};
    end
    if (k[i] <= nd) begin
      v  = (k[i] - 1) / s1;
      pm = 4'd0;
      for (int b = 0; b < v; b++) pm[b] = fm[b];
      return {v[1], v[0], 1'b1, 1'b0, 1'b0, 3'($countones(pm)), pm};
    end
    return {2'b00, 1'b0, 1'b1, (fm == 4'd0), 3'($countones(fm)), fm};
  endfunction

  function automatic logic [11:0] out_vec(input int i);
    return {gate_a[i], gate_b[i], busy[i], done[i], pass[i], err_count[i], err_mask[i]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en)
        for (int i = 0; i < N; i++)
          check($sformatf("inst%0d outputs vs model", i), 64'(out_vec(i)), 64'(exp_out(i)));
    end
  endtask

  // ---------------- directed sweep helper ----------------
  int         d_cyc  [N];
  int         d_num  [N];
  logic [3:0] d_mask [N];
  logic [2:0] d_cnt  [N];
  logic       d_pass [N];

  // Pulse start, optionally re-pulse it in cycle `repulse`, and record the
  // first done cycle and results of each instance within a bounded window.
  task automatic run_sweep(input int repulse);
    for (int i = 0; i < N; i++) begin
      d_cyc[i] = -1;
      d_num[i] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == repulse);
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          d_num[i]++;
          if (d_cyc[i] < 0) begin
            d_cyc[i]  = c;
            d_mask[i] = err_mask[i];
            d_cnt[i]  = err_count[i];
            d_pass[i] = pass[i];
          end
        end
      end
    end
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold, rst_at;
    rst_n   = 1'b0;
    start   = 1'b0;
    gate_fn = {4'b0111, 4'b0111, 4'b0111};
    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset outputs all zero", 64'({out_vec(0), out_vec(1), out_vec(2)}), 64'd0);
    #2 rst_n = 1'b1;

    // Correct NAND on 0 and 2; stuck-at-0 on the stop-on-fail instance.
    gate_fn[0] = 4'b0111;
    gate_fn[1] = 4'b0000;
    gate_fn[2] = 4'b0111;
    run_sweep(-1);
    check("nand s2 done cycle", 64'(d_cyc[0]), 64'd13);
    check("nand s2 results", 64'({d_pass[0], d_cnt[0], d_mask[0]}), 64'({1'b1, 3'd0, 4'b0000}));
    check("stop s2 done cycle", 64'(d_cyc[1]), 64'd4);
    check("stop s2 results", 64'({d_pass[1], d_cnt[1], d_mask[1]}), 64'({1'b0, 3'd1, 4'b0001}));
    check("stop s2 gate inputs idle", 64'({gate_a[1], gate_b[1]}), 64'd0);
    check("nand s0 done cycle", 64'(d_cyc[2]), 64'd5);
    check("nand s0 pass", 64'(d_pass[2]), 64'd1);

    // AND gate with a start re-pulse mid-sweep.
    gate_fn[0] = 4'b1000;
    run_sweep(5);
    check("and done cycle", 64'(d_cyc[0]), 64'd13);
    check("and single done", 64'(d_num[0]), 64'd1);
    check("and results", 64'({d_pass[0], d_cnt[0], d_mask[0]}), 64'({1'b0, 3'd4, 4'b1111}));

    // Stuck-at-1 output.
    gate_fn[0] = 4'b1111;
    run_sweep(-1);
    check("stuck1 results", 64'({d_pass[0], d_cnt[0], d_mask[0]}), 64'({1'b0, 3'd1, 4'b1000}));
    check("stuck1 results held", 64'({pass[0], err_count[0], err_mask[0]}), 64'({1'b0, 3'd1, 4'b1000}));

    // Reset in cycle 5 of a sweep aborts it.
    gate_fn[0] = 4'b0111;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check("reset abort outputs", 64'({out_vec(0), out_vec(1), out_vec(2)}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("no done under reset", 64'(done), 64'd0);
    end
    #2 rst_n = 1'b1;
    run_sweep(-1);
    check("fresh sweep after reset", 64'({d_cyc[0], d_pass[0]}), 64'({32'd13, 1'b1}));

    // Randomized rounds: random gates, held starts, stray starts, resets.
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) gate_fn[i] = 4'($urandom);
      hold   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 35)) : 1;
      rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 14)) : -1;
      for (int c = 0; c < 36; c++) begin
        if (c < hold) start = 1'b1;
        else          start = ($urandom_range(0, 7) == 0);
        if (rst_at >= 0 && c == rst_at)     #2 rst_n = 1'b0;
        if (rst_at >= 0 && c == rst_at + 2) #2 rst_n = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
